// File: rtl/reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// reg_write_arbiter
// Round-robin arbiter sharing the single write port of the register bank
// among N_REQ requesters. At most one requester is granted per cycle; its
// address/data are registered onto the bank write port and a one-cycle
// grant is returned as acknowledgment. A requester that raises req_lock
// together with req may keep the port for up to MAX_BURST back-to-back
// writes.
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | nothing granted last cycle
// GRANT | one unlocked write granted last cycle
// LOCKED| r_owner holds the port for a burst (r_burst grants so far)
//
// Ports
//   clk       : clock, rising edge
//   reset     : synchronous, active-low
//   req       : per-requester write request
//   req_lock  : per-requester burst-lock request (qualified by req)
//   req_addr  : packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_data  : packed data, requester i at [i*WIDTH +: WIDTH]
//   grant     : one-hot acknowledgment, registered
//   wr_en     : bank write enable
//   wr_addr   : bank write address (holds when nothing granted)
//   wr_data   : bank write data (holds when nothing granted)
//   busy      : high while in LOCKED
// ---------------------------------------------------------------------------
module reg_write_arbiter #(
    parameter int N_REQ     = 4,
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 3,
    parameter int MAX_BURST = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*WIDTH-1:0]    req_data,
    output logic [N_REQ-1:0]          grant,
    output logic                      wr_en,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [WIDTH-1:0]          wr_data,
    output logic                      busy
);

    localparam int PTR_W   = $clog2(N_REQ);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT  = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [PTR_W:0]     N_EXT     = (PTR_W+1)'(N_REQ);
    localparam logic [PTR_W-1:0]   P_LAST    = PTR_W'(N_REQ - 1);
    localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

    logic [1:0]          r_state;
    logic [N_REQ-1:0]    r_grant;
    logic                r_wr_en;
    logic [ADDR_W-1:0]   r_wr_addr;
    logic [WIDTH-1:0]    r_wr_data;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_owner;
    logic [BURST_W-1:0]  r_burst;

    logic [N_REQ-1:0]    w_elig;
    logic [2*N_REQ-1:0]  w_dbl;
    logic [N_REQ-1:0]    w_rot;
    logic [PTR_W-1:0]    w_off;
    logic [PTR_W:0]      w_sum;
    logic [PTR_W-1:0]    w_win;
    logic                w_found;
    logic                w_lock_cont;
    logic [PTR_W-1:0]    w_sel;
    logic [ADDR_W-1:0]   w_addr_arr [N_REQ];
    logic [WIDTH-1:0]    w_data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
        assign w_data_arr[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Last cycle's grantee is masked so a still-held request is not written twice.
    assign w_elig = req & ~r_grant;

    // Rotate so bit 0 corresponds to ptr, pick the lowest set bit, rotate back.
    always_comb begin
        w_dbl   = {w_elig, w_elig};
        w_rot   = N_REQ'(w_dbl >> r_ptr);
        w_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (|(w_rot & (N_REQ'(1) << k))) begin
                w_off = PTR_W'(k);
            end
        end
        w_sum   = {1'b0, r_ptr} + {1'b0, w_off};
        w_win   = (w_sum >= N_EXT) ? PTR_W'(w_sum - N_EXT) : PTR_W'(w_sum);
        w_found = |w_elig;
    end

    // The owner bypasses masking while its burst continues.
    assign w_lock_cont = (r_state == ST_LOCKED) && req[r_owner] && req_lock[r_owner]
                         && (r_burst < BURST_MAX);
    assign w_sel       = w_lock_cont ? r_owner : w_win;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_burst   <= '0;
        end else if (w_lock_cont || w_found) begin
            r_grant   <= N_REQ'(1) << w_sel;
            r_wr_en   <= 1'b1;
            r_wr_addr <= w_addr_arr[w_sel];
            r_wr_data <= w_data_arr[w_sel];
            if (w_lock_cont) begin
                r_burst <= r_burst + BURST_W'(1);
            end else begin
                r_ptr <= (w_win == P_LAST) ? '0 : w_win + PTR_W'(1);
                if (req_lock[w_win]) begin
                    r_state <= ST_LOCKED;
                    r_owner <= w_win;
                    r_burst <= BURST_W'(1);
                end else begin
                    r_state <= ST_GRANT;
                    r_burst <= '0;
                end
            end
        end else begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_wr_en <= 1'b0;
            r_burst <= '0;
        end
    end

    assign grant   = r_grant;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign busy    = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_reg_write_arbiter
// Directed bench for reg_write_arbiter (N_REQ=4, WIDTH=16, ADDR_W=3,
// MAX_BURST=8). Inputs change 1 ns after a rising edge; outputs are checked
// at the same point, reflecting the decision made on that edge.
// ---------------------------------------------------------------------------
module tb_reg_write_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [3:0]  req_lock;
    logic [11:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  grant;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;

    logic [2:0]  a [4];
    logic [15:0] d [4];

    int n_checks = 0;
    int n_errors = 0;

    assign req_addr = {a[3], a[2], a[1], a[0]};
    assign req_data = {d[3], d[2], d[1], d[0]};

    reg_write_arbiter #(
        .N_REQ(4), .WIDTH(16), .ADDR_W(3), .MAX_BURST(8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .req_lock (req_lock),
        .req_addr (req_addr),
        .req_data (req_data),
        .grant    (grant),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_port(input string tag, input logic [3:0] g, input logic en,
                            input logic bz);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".wr_en"}, 32'(wr_en), 32'(en));
        chk({tag, ".busy"},  32'(busy),  32'(bz));
    endtask

    logic [3:0] exp_g;

    initial begin
        reset    = 1'b0;
        req      = 4'b1111;
        req_lock = 4'b0000;
        a[0] = 3'd0; a[1] = 3'd1; a[2] = 3'd2; a[3] = 3'd3;
        d[0] = 16'h1000; d[1] = 16'h1001; d[2] = 16'h1002; d[3] = 16'h1003;

        // Reset held 3 cycles with every requester asking
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_port("reset", 4'b0000, 1'b0, 1'b0);
            chk("reset.wr_data", 32'(wr_data), 32'h0000);
        end

        // Single write from requester 1
        reset = 1'b1;
        req   = 4'b0010;
        a[1]  = 3'd5;
        d[1]  = 16'hBEEF;
        tick();
        chk_port("single", 4'b0010, 1'b1, 1'b0);
        chk("single.wr_addr", 32'(wr_addr), 32'd5);
        chk("single.wr_data", 32'(wr_data), 32'hBEEF);
        tick();
        chk_port("single_masked", 4'b0000, 1'b0, 1'b0);
        chk("single_hold.wr_data", 32'(wr_data), 32'hBEEF);
        chk("single_hold.wr_addr", 32'(wr_addr), 32'd5);
        req = 4'b0000;

        // Reset to return ptr to 0
        reset = 1'b0;
        tick();
        reset = 1'b1;
        a[1] = 3'd1;
        d[1] = 16'h1001;

        // Round-robin over all four, each dropping after its grant
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_g = 4'(1 << i);
            chk_port("rr", exp_g, 1'b1, 1'b0);
            chk("rr.wr_addr", 32'(wr_addr), 32'(i));
            chk("rr.wr_data", 32'(wr_data), 32'h1000 + 32'(i));
            req = req & ~exp_g;
        end
        tick();
        chk_port("rr_idle", 4'b0000, 1'b0, 1'b0);

        // Wrap: ptr is back at 0, so 0 wins before 3
        req = 4'b1001;
        tick();
        chk_port("wrap0", 4'b0001, 1'b1, 1'b0);
        req = 4'b1000;
        tick();
        chk_port("wrap3", 4'b1000, 1'b1, 1'b0);
        chk("wrap3.wr_data", 32'(wr_data), 32'h1003);
        req = 4'b0000;
        tick();

        // Fairness: 0 and 2 re-request, each dropping for a cycle after a grant
        req = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp_g = (i % 2 == 0) ? 4'b0001 : 4'b0100;
            chk_port("fair", exp_g, 1'b1, 1'b0);
            req = 4'b0101 & ~exp_g;
        end
        req = 4'b0000;
        tick();
        chk_port("fair_idle", 4'b0000, 1'b0, 1'b0);

        // Reset so the lock burst starts from ptr 0
        reset = 1'b0;
        tick();
        reset = 1'b1;

        // Lock burst: requester 1 locked, requester 3 waiting
        req      = 4'b1010;
        req_lock = 4'b0010;
        a[3]     = 3'd7;
        d[3]     = 16'h3333;
        a[1]     = 3'd4;
        for (int k = 1; k <= 8; k++) begin
            d[1] = 16'(32'hA000 + k);
            tick();
            chk_port("burst", 4'b0010, 1'b1, 1'b1);
            chk("burst.wr_data", 32'(wr_data), 32'hA000 + 32'(k));
        end
        tick();
        chk_port("burst_end", 4'b1000, 1'b1, 1'b0);
        chk("burst_end.wr_addr", 32'(wr_addr), 32'd7);
        chk("burst_end.wr_data", 32'(wr_data), 32'h3333);
        req      = 4'b0000;
        req_lock = 4'b0000;
        tick();
        chk_port("burst_idle", 4'b0000, 1'b0, 1'b0);

        // Reset mid-burst after the 4th locked grant
        req      = 4'b0010;
        req_lock = 4'b0010;
        for (int k = 1; k <= 4; k++) begin
            d[1] = 16'(32'hC000 + k);
            tick();
            chk_port("midburst", 4'b0010, 1'b1, 1'b1);
        end
        reset = 1'b0;
        tick();
        chk_port("midburst_rst", 4'b0000, 1'b0, 1'b0);
        chk("midburst_rst.ptr", 32'(dut.r_ptr), 32'd0);
        chk("midburst_rst.wr_data", 32'(wr_data), 32'h0000);
        reset    = 1'b1;
        req      = 4'b0000;
        req_lock = 4'b0000;
        tick();
        chk_port("final_idle", 4'b0000, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Round-robin arbiter that shares the single write port of the 16-bit dff-based register bank among `N_REQ` requesters (e.g. ALU writeback, load unit, debug port). Each cycle it selects at most one requester, registers that requester's address and data onto the bank write port, and returns a one-cycle grant as acknowledgment. A lock mode lets one requester issue back-to-back writes for a bounded burst.

## Interface
- `N_REQ`, 4, number of requesters (2–8)
- `WIDTH`, 16, data width of the register bank
- `ADDR_W`, 3, register address width
- `MAX_BURST`, 8, maximum consecutive grants to one locked requester (≥2)

- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-low
- `req`  in  N_REQ  per-requester write request
- `req_lock`  in  N_REQ  per-requester burst-lock request, qualified by `req`
- `req_addr`  in  N_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- `req_data`  in  N_REQ*WIDTH  packed data; requester i at bits [i*WIDTH +: WIDTH]
- `grant`  out  N_REQ  one-hot acknowledgment; the write of requester i is on the port this cycle
- `wr_en`  out  1  write enable to the register bank
- `wr_addr`  out  ADDR_W  write address to the register bank
- `wr_data`  out  WIDTH  write data to the register bank
- `busy`  out  1  high while in LOCKED state

## Operation
- States: IDLE, GRANT, LOCKED. State, `grant`, `wr_*`, the priority pointer `ptr`, and the burst counter are all registered.
- Eligible set `elig = req & ~grant`. The requester granted in the current cycle is masked for the next decision; this prevents double-writing a request that is still held.
- Selection: first set bit of `elig` scanning from `ptr` upward, modulo N_REQ.
- Transitions:
  - IDLE/GRANT: if no requester is eligible, go to IDLE, `grant=0`, `wr_en=0`. Otherwise grant winner w, then:
    - `req_lock[w]=1`: go to LOCKED, burst count = 1.
    - Else: go to GRANT.
    - In both cases `ptr` ← (w+1) mod N_REQ.
  - LOCKED (owner o): if `req[o] & req_lock[o]` and burst count < MAX_BURST, grant o again (masking not applied to the owner) and increment the count. Otherwise leave LOCKED and perform the normal selection from `ptr` in the same cycle. The owner is excluded from that selection because it is masked.
- When granting w: `wr_addr`/`wr_data` ← w's packed fields and `wr_en=1`. When nothing is granted, `wr_addr`/`wr_data` hold their previous values.
- Requester protocol:
  - Hold `req`, `req_addr`, and `req_data` stable until `grant[i]` is seen high.
  - In the cycle after that grant, drop `req` or present the next item.
  - In LOCKED, present a new item each cycle `grant[i]` is high.
- `busy` = (state == LOCKED).

## Timing
- Reset (`reset`=0 at a rising edge): state=IDLE, `grant=0`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `ptr=0`, burst count=0. Reset mid-burst aborts the burst; no partial write is issued.
- Latency: `req` sampled at edge t produces `grant`/`wr_en`/data valid after edge t. The bank captures the write at edge t+1.
- Throughput: one write per cycle overall. A single unlocked requester gets at most one grant every 2 cycles. A locked requester gets up to MAX_BURST consecutive grants.
- Simultaneous requests: exactly one grant, by round-robin from `ptr`. `grant` is never more than one-hot.
- Requester dropping `req` while ungranted: no grant and no write for it.
- Wrap-around: `ptr` after granting N_REQ-1 is 0.

## Test plan
- Reset: drive `reset`=0 for 3 cycles with all `req`=1 → `grant=0`, `wr_en=0`, `wr_data=16'h0000`, `busy=0` throughout.
- Single write: `req`=4'b0010, addr1=3'd5, data1=16'hBEEF → the next cycle has `grant`=4'b0010, `wr_en=1`, `wr_addr=5`, `wr_data=16'hBEEF`. With `req` still held, the following cycle has `grant=0`.
- Round-robin: `req`=4'b1111 held, each requester dropping `req` one cycle after its grant → grants 0,1,2,3 in order. Then `req`=4'b1001 → grant 0 then 3 (`ptr` wrapped).
- Fairness: requesters 0 and 2 continuously re-request (drop for one cycle after each grant) → grants alternate 0,2,0,2; neither starves.
- Lock burst: `req[1]`=`req_lock[1]`=1 held 12 cycles with `req[3]`=1, MAX_BURST=8 → 8 consecutive `grant`=4'b0010 with `busy=1`, then `grant`=4'b1000 and `busy=0`.
- Reset mid-burst: assert `reset`=0 during grant 4 of a locked burst → next cycle `grant=0`, `wr_en=0`, `busy=0`, `ptr=0`.
